// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle control unit.
package cu_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWR,
    S_MEMWB, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;
  localparam logic [2:0] ALU_LSR = 3'b110;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  function automatic logic [2:0] cmd_alu(input logic [3:0] cmd, input logic [1:0] sh);
    case (cmd)
      CMD_ADD:          return ALU_ADD;
      CMD_SUB, CMD_CMP: return ALU_SUB;
      CMD_AND:          return ALU_AND;
      CMD_ORR:          return ALU_ORR;
      CMD_EOR:          return ALU_EOR;
      CMD_MOV:          return (sh == 2'b01) ? ALU_LSR : ALU_MOV;
      default:          return ALU_ADD;
    endcase
  endfunction

  function automatic logic cmd_known(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD, CMD_SUB, CMD_CMP, CMD_AND, CMD_ORR, CMD_EOR, CMD_MOV: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cu_cond_check.sv
// Condition-code evaluation: cond field against NZCV. 1111 never executes.
module cu_cond_check
  import cu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cu_multicycle_ctrl.sv
// Multicycle ARM-subset control FSM with NZCV register and memory wait-state handshake.
module cu_multicycle_ctrl
  import cu_pkg::*;
#(
  parameter int         ALUCTRL_W     = 3,
  parameter bit         MEM_HANDSHAKE = 1'b1,
  parameter logic [3:0] FLAGS_RST     = 4'b0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           cond,
  input  logic [1:0]           op,
  input  logic [5:0]           funct,
  input  logic [3:0]           rd,
  input  logic [1:0]           sh,
  input  logic [3:0]           alu_flags,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_w,
  output logic                 ir_write,
  output logic                 reg_w,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic [1:0]           reg_src,
  output logic [ALUCTRL_W-1:0] alu_ctrl,
  output logic [3:0]           flags,
  output logic                 illegal_op
);

  state_t     state;
  logic [1:0] op_q;
  logic [4:0] funct_q;
  logic [3:0] rd_q;
  logic [1:0] sh_q;
  logic       cond_ex_q;
  logic [3:0] flags_q;
  logic       cond_ex;
  logic       ready;

  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  cu_cond_check u_cond (.cond(cond), .flags(flags_q), .cond_ex(cond_ex));

  logic [3:0] cmd_q;
  logic       is_cmp, is_arith, no_write, set_flags;
  assign cmd_q     = funct_q[4:1];
  assign is_cmp    = (cmd_q == CMD_CMP);
  assign is_arith  = (cmd_q == CMD_ADD) | (cmd_q == CMD_SUB) | is_cmp;
  assign no_write  = is_cmp | ~cmd_known(cmd_q);
  assign set_flags = funct_q[0] | is_cmp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      flags_q   <= FLAGS_RST;
      op_q      <= OP_DP;
      funct_q   <= '0;
      rd_q      <= '0;
      sh_q      <= '0;
      cond_ex_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH:  if (ready) state <= S_DECODE;
        S_DECODE: begin
          // Later states use only these copies; the IR inputs may move on.
          op_q      <= op;
          funct_q   <= funct[4:0];
          rd_q      <= rd;
          sh_q      <= sh;
          cond_ex_q <= cond_ex;
          if (!cond_ex) state <= S_FETCH;
          else begin
            case (op)
              OP_DP:   state <= funct[5] ? S_EXECI : S_EXECR;
              OP_MEM:  state <= S_MEMADR;
              OP_BR:   state <= S_BRANCH;
              default: state <= S_FETCH;
            endcase
          end
        end
        S_MEMADR: state <= funct_q[0] ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (ready) state <= S_MEMWB;
        S_MEMWR:  if (ready) state <= S_FETCH;
        S_EXECR, S_EXECI: begin
          state <= S_ALUWB;
          if (cond_ex_q && set_flags) begin
            flags_q[3:2] <= alu_flags[3:2];
            if (is_arith) flags_q[1:0] <= alu_flags[1:0];
          end
        end
        default:  state <= S_FETCH;
      endcase
    end
  end

  logic       pc_w, ir_w, mem_w_i, reg_w_i, ill;
  logic [2:0] alu3;
  logic [1:0] f_op;

  always_comb begin
    pc_w       = 1'b0;
    ir_w       = 1'b0;
    mem_w_i    = 1'b0;
    reg_w_i    = 1'b0;
    ill        = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu3       = ALU_ADD;
    // DECODE drives register reads, so it must see the live opcode.
    f_op       = (state == S_DECODE) ? op : op_q;
    imm_src    = (f_op == OP_ILL) ? 2'b00 : f_op;
    reg_src    = {f_op == OP_MEM, f_op == OP_BR};
    case (state)
      S_FETCH: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_w       = ready;
        pc_w       = ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        ill       = (op == OP_ILL);
      end
      S_MEMADR: alu_src_b = 2'b01;
      S_MEMRD:  adr_src = 1'b1;
      S_MEMWR: begin
        adr_src = 1'b1;
        mem_w_i = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w_i    = 1'b1;
        pc_w       = (rd_q == 4'hF);
      end
      S_EXECR:  alu3 = cmd_alu(cmd_q, sh_q);
      S_EXECI: begin
        alu_src_b = 2'b01;
        alu3      = cmd_alu(cmd_q, sh_q);
      end
      S_ALUWB: begin
        reg_w_i = ~no_write;
        pc_w    = ~no_write & (rd_q == 4'hF);
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_w       = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_write   = rst_n & pc_w;
  assign ir_write   = rst_n & ir_w;
  assign mem_w      = rst_n & mem_w_i;
  assign reg_w      = rst_n & reg_w_i;
  assign illegal_op = rst_n & ill;
  assign alu_ctrl   = ALUCTRL_W'(alu3);
  assign flags      = flags_q;

endmodule

// File: tb/tb_cu_multicycle_ctrl.sv
// Directed bench: instruction table with per-instruction cycle/strobe counts, plus wait-state and reset sequences.
module tb_cu_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [1:0] sh;
  logic [3:0] alu_flags;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_w, ir_write, reg_w, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, reg_src;
  logic [2:0] alu_ctrl;
  logic [3:0] flags;

  int checks = 0;
  int errors = 0;

  cu_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cond(cond), .op(op), .funct(funct), .rd(rd), .sh(sh),
    .alu_flags(alu_flags), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_w(mem_w), .ir_write(ir_write), .reg_w(reg_w), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src), .reg_src(reg_src),
    .alu_ctrl(alu_ctrl), .flags(flags), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  af;
    int          len, regw, pcw, ill, memw;
    logic [2:0]  alu2;
    logic [3:0]  flg;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins);
    cond  = ins[31:28];
    op    = ins[27:26];
    funct = ins[25:20];
    rd    = ins[15:12];
    sh    = ins[6:5];
  endtask

  // Entry: low half of a FETCH cycle. Exit: low half of the next FETCH.
  task automatic run(input logic [31:0] ins, input logic [3:0] af, input logic [31:0] nrdy,
                     output int len, output int regw, output int pcw, output int ill,
                     output int memw, output int irw, output logic [2:0] alu2);
    bit done = 1'b0;
    drive(ins);
    alu_flags = af;
    len = 0; regw = 0; pcw = 0; ill = 0; memw = 0; irw = 0; alu2 = 3'b111;
    for (int i = 0; i < 40 && !done; i++) begin
      mem_ready = (len < 32) ? ~nrdy[len] : 1'b1;
      #1;
      if (irw > 0 && alu_src_a == 2'b01 && result_src == 2'b10) done = 1'b1;
      else begin
        regw += int'(reg_w);
        memw += int'(mem_w);
        ill  += int'(illegal_op);
        irw  += int'(ir_write);
        if (pc_write && !ir_write) pcw++;
        if (len == 2) alu2 = alu_ctrl;
        len++;
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout %h: no return to FETCH after %0d cycles", ins, len);
    end
  endtask

  vec_t vt[19];
  int len, regw, pcw, ill, memw, irw;
  logic [2:0] alu2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            ins           af     len rw pw il mw alu     flags
    vt[0]  = '{32'hE0821003, 4'b1111, 4, 1, 0, 0, 0, 3'b000, 4'b0000}; // ADD
    vt[1]  = '{32'hE1510002, 4'b0100, 4, 0, 0, 0, 0, 3'b001, 4'b0100}; // CMP
    vt[2]  = '{32'h0A000001, 4'b1111, 3, 0, 1, 0, 0, 3'b000, 4'b0100}; // BEQ taken
    vt[3]  = '{32'h1A000001, 4'b1111, 2, 0, 0, 0, 0, 3'b111, 4'b0100}; // BNE not taken
    vt[4]  = '{32'hE2921005, 4'b1011, 4, 1, 0, 0, 0, 3'b000, 4'b1011}; // ADDS imm
    vt[5]  = '{32'hE0121003, 4'b0111, 4, 1, 0, 0, 0, 3'b010, 4'b0111}; // ANDS keeps CV
    vt[6]  = '{32'hE183F003, 4'b0000, 4, 1, 1, 0, 0, 3'b011, 4'b0111}; // ORR pc
    vt[7]  = '{32'hE0221003, 4'b0000, 4, 1, 0, 0, 0, 3'b100, 4'b0111}; // EOR
    vt[8]  = '{32'hE1A01022, 4'b0000, 4, 1, 0, 0, 0, 3'b110, 4'b0111}; // MOV LSR
    vt[9]  = '{32'hE1A01002, 4'b0000, 4, 1, 0, 0, 0, 3'b101, 4'b0111}; // MOV
    vt[10] = '{32'hE0C21003, 4'b0000, 4, 0, 0, 0, 0, 3'b000, 4'b0111}; // unknown cmd
    vt[11] = '{32'hE591F004, 4'b0000, 5, 1, 1, 0, 0, 3'b000, 4'b0111}; // LDR pc
    vt[12] = '{32'hE5812004, 4'b0000, 4, 0, 0, 0, 1, 3'b000, 4'b0111}; // STR
    vt[13] = '{32'hEC000000, 4'b0000, 2, 0, 0, 1, 0, 3'b111, 4'b0111}; // op=11
    vt[14] = '{32'hF0821003, 4'b0000, 2, 0, 0, 0, 0, 3'b111, 4'b0111}; // cond NV
    vt[15] = '{32'hBA000000, 4'b0000, 3, 0, 1, 0, 0, 3'b000, 4'b0111}; // BLT taken
    vt[16] = '{32'h8A000000, 4'b0000, 2, 0, 0, 0, 0, 3'b111, 4'b0111}; // BHI not taken
    vt[17] = '{32'h11510002, 4'b1000, 2, 0, 0, 0, 0, 3'b111, 4'b0111}; // CMPNE skipped
    vt[18] = '{32'hE0521003, 4'b1010, 4, 1, 0, 0, 0, 3'b001, 4'b1010}; // SUBS

    rst_n = 1'b0; mem_ready = 1'b1; alu_flags = 4'b1111;
    drive(32'h0);
    @(negedge clk); @(negedge clk); #1;
    chk("rst flags", flags, 4'b0000);
    chk("rst ir_write", ir_write, 1'b0);
    chk("rst pc_write", pc_write, 1'b0);
    chk("rst fetch src_a", alu_src_a, 2'b01);
    chk("rst fetch result_src", result_src, 2'b10);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      run(vt[i].ins, vt[i].af, 32'h0, len, regw, pcw, ill, memw, irw, alu2);
      chk($sformatf("v%0d len", i),   len,   vt[i].len);
      chk($sformatf("v%0d reg_w", i), regw,  vt[i].regw);
      chk($sformatf("v%0d pc_w", i),  pcw,   vt[i].pcw);
      chk($sformatf("v%0d ill", i),   ill,   vt[i].ill);
      chk($sformatf("v%0d mem_w", i), memw,  vt[i].memw);
      chk($sformatf("v%0d alu", i),   alu2,  vt[i].alu2);
      chk($sformatf("v%0d flags", i), flags, vt[i].flg);
    end

    // LDR pc with three not-ready cycles in MEMRD
    run(32'hE591F004, 4'b0000, 32'h38, len, regw, pcw, ill, memw, irw, alu2);
    chk("ldr wait len", len, 8);
    chk("ldr wait reg_w", regw, 1);
    chk("ldr wait pc_w", pcw, 1);

    // STR with two not-ready cycles in MEMWR
    run(32'hE5812004, 4'b0000, 32'h18, len, regw, pcw, ill, memw, irw, alu2);
    chk("str wait len", len, 6);
    chk("str wait mem_w", memw, 3);
    chk("str wait reg_w", regw, 0);

    // Fetch stalled two cycles
    run(32'hE0821003, 4'b0000, 32'h3, len, regw, pcw, ill, memw, irw, alu2);
    chk("fetch wait len", len, 6);
    chk("fetch wait ir_w", irw, 1);
    chk("fetch wait reg_w", regw, 1);

    // Decode latch: IR fields scrambled after DECODE of ADD r15
    drive(32'hE082F003); mem_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    drive(32'h0);
    #1 chk("latch alu_ctrl", alu_ctrl, 3'b000);
    @(negedge clk); #1;
    chk("latch reg_w", reg_w, 1'b1);
    chk("latch pc_w", pc_write, 1'b1);
    @(negedge clk); #1;

    // Reset in the middle of a waiting store
    drive(32'hE5812004); mem_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("memwr mem_w", mem_w, 1'b1);
    rst_n = 1'b0;
    #1 chk("rst gates mem_w", mem_w, 1'b0);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("abort flags", flags, 4'b0000);
    chk("abort mem_w", mem_w, 1'b0);
    chk("abort ir_w gated", ir_write, 1'b0);
    chk("abort fetch src_a", alu_src_a, 2'b01);
    chk("abort fetch result", result_src, 2'b10);
    rst_n = 1'b1;
    #1 chk("post rst ir_w", ir_write, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
